// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types, widths and overflow helper for the shift sequencer
package shift_seq_pkg;

    localparam int SR_W  = 8;
    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_H,
        SHIFT_L,
        CAPTURE,
        DONE
    } seqStateT;

    // True when any operand bit would land beyond Q7 after shifting left by amt.
    function automatic logic ovfCalc(input logic [NIB_W-1:0] op, input logic [31:0] amt);
        logic [SR_W+NIB_W-1:0] wide;
        if (amt >= 32'(SR_W)) begin
            return |op;
        end
        wide = {{SR_W{1'b0}}, op} << amt;
        return |wide[SR_W+NIB_W-1:SR_W];
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - request/result and shift-register bus; ovf present with SHIFT_SEQ_OVF_EN
interface shift_seq_ctrl_if
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 3
);
    logic             start;
    logic [NIB_W-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic [NIB_W-1:0] sr_d;
    logic             sr_load;
    logic             sr_shift;
    logic [SR_W-1:0]  sr_q;
    logic [NIB_W-1:0] result_lo;
    logic [NIB_W-1:0] result_hi;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, operand, amount, sr_q,
        input  sr_d, sr_load, sr_shift, result_lo, result_hi, busy, done
`ifdef SHIFT_SEQ_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, operand, amount, sr_q,
        output sr_d, sr_load, sr_shift, result_lo, result_hi, busy, done
`ifdef SHIFT_SEQ_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/shift_seq_pulse.sv
// rtl/shift_seq_pulse.sv - half-period counter producing the flop-driven SHIFT clock phases
module shift_seq_pulse #(
    parameter int SHIFT_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic nextHigh,
    output logic srShift,
    output logic phaseEnd
);

    logic [2:0] cnt;

    assign phaseEnd = active && (cnt == 3'(SHIFT_HALF - 1));

    // srShift follows the next state so the pin comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            srShift <= 1'b0;
        end else begin
            srShift <= nextHigh;
            if (!active || phaseEnd) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load/shift/capture sequencer for the nibble-load shift register; optional SHIFT_SEQ_OVF_EN
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int SHIFT_HALF = 1,
    parameter int AMT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    shift_seq_ctrl_if.slave bus
);

    seqStateT         state;
    seqStateT         nextState;
    logic [NIB_W-1:0] opReg;
    logic [AMT_W-1:0] remaining;
    logic [NIB_W-1:0] resLo;
    logic [NIB_W-1:0] resHi;
    logic             phaseEnd;
    logic             shiftActive;
    logic             nextHigh;
    logic             srShift;
`ifdef SHIFT_SEQ_OVF_EN
    logic [AMT_W-1:0] amtReg;
    logic             ovfReg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opReg     <= '0;
            remaining <= '0;
            resLo     <= '0;
            resHi     <= '0;
`ifdef SHIFT_SEQ_OVF_EN
            amtReg    <= '0;
            ovfReg    <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (state == IDLE && bus.start) begin
                opReg     <= bus.operand;
                remaining <= bus.amount;
`ifdef SHIFT_SEQ_OVF_EN
                amtReg    <= bus.amount;
`endif
            end
            if (state == SHIFT_L && phaseEnd) begin
                remaining <= remaining - 1'b1;
            end
            if (state == CAPTURE) begin
                resLo  <= bus.sr_q[NIB_W-1:0];
                resHi  <= bus.sr_q[SR_W-1:NIB_W];
`ifdef SHIFT_SEQ_OVF_EN
                ovfReg <= ovfCalc(opReg, 32'(amtReg));
`endif
            end
        end
    end

    // Terminal test on the pre-decrement count keeps the maximum amount from wrapping.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = LOAD;
            LOAD:    nextState = (remaining != '0) ? SHIFT_H : CAPTURE;
            SHIFT_H: if (phaseEnd) nextState = SHIFT_L;
            SHIFT_L: if (phaseEnd) nextState = (remaining == AMT_W'(1)) ? CAPTURE : SHIFT_H;
            CAPTURE: nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign shiftActive = (state == SHIFT_H) || (state == SHIFT_L);
    assign nextHigh    = (nextState == SHIFT_H);

    shift_seq_pulse #(
        .SHIFT_HALF(SHIFT_HALF)
    ) u_pulse (
        .clk     (clk),
        .rst     (rst),
        .active  (shiftActive),
        .nextHigh(nextHigh),
        .srShift (srShift),
        .phaseEnd(phaseEnd)
    );

    assign bus.sr_d      = opReg;
    assign bus.sr_load   = (state == LOAD);
    assign bus.sr_shift  = srShift;
    assign bus.result_lo = resLo;
    assign bus.result_hi = resHi;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
`ifdef SHIFT_SEQ_OVF_EN
    assign bus.ovf       = ovfReg;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed bench for shift_seq_ctrl with a behavioural shift register; ovf checks with SHIFT_SEQ_OVF_EN
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.AMT_W(3)) busA ();
    shift_seq_ctrl_if #(.AMT_W(3)) busB ();

    shift_seq_ctrl #(.SHIFT_HALF(1), .AMT_W(3)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
    shift_seq_ctrl #(.SHIFT_HALF(2), .AMT_W(3)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));

    logic [7:0] qA;
    logic [7:0] qB;
    int edgesA = 0;
    int edgesB = 0;
    int checks = 0;
    int failures = 0;

    assign busA.sr_q = qA;
    assign busB.sr_q = qB;

    always @(posedge busA.sr_shift or negedge clk) begin
        if (busA.sr_load)               qA <= {4'b0, busA.sr_d};
        else if (busA.sr_shift && clk)  qA <= {qA[6:0], 1'b0};
    end
    always @(posedge busB.sr_shift or negedge clk) begin
        if (busB.sr_load)               qB <= {4'b0, busB.sr_d};
        else if (busB.sr_shift && clk)  qB <= {qB[6:0], 1'b0};
    end
    always @(posedge busA.sr_shift) edgesA++;
    always @(posedge busB.sr_shift) edgesB++;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setIn(input bit sel, input logic st, input logic [3:0] op, input logic [2:0] amt);
        if (sel) begin
            busB.start = st; busB.operand = op; busB.amount = amt;
        end else begin
            busA.start = st; busA.operand = op; busA.amount = amt;
        end
    endtask

    function automatic logic [3:0] sigOf(input bit sel);
        return sel ? {busB.busy, busB.done, busB.sr_load, busB.sr_shift}
                   : {busA.busy, busA.done, busA.sr_load, busA.sr_shift};
    endfunction

    function automatic logic [7:0] resOf(input bit sel);
        return sel ? {busB.result_hi, busB.result_lo} : {busA.result_hi, busA.result_lo};
    endfunction

    function automatic logic [19:0] allOutA();
        return {busA.busy, busA.done, busA.sr_load, busA.sr_shift,
                busA.sr_d, busA.result_hi, busA.result_lo};
    endfunction

    task automatic runOp(input string tag, input bit sel, input logic [3:0] op, input logic [2:0] amt,
                         input int expLat, input logic [7:0] expRes, input int expHigh, input int restartAt);
        int lat, dones, loads, highs, overlap, e0;
        logic [3:0] s;
        lat = 0; dones = 0; loads = 0; highs = 0; overlap = 0;
        @(negedge clk);
        e0 = sel ? edgesB : edgesA;
        setIn(sel, 1'b1, op, amt);
        @(posedge clk);
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            setIn(sel, lat == restartAt, op, amt);
            s = sigOf(sel);
            loads   += int'(s[1]);
            highs   += int'(s[0]);
            overlap += int'(s[1] & s[0]);
            if (s[2]) begin
                dones++;
                break;
            end
        end
        setIn(sel, 1'b0, op, amt);
        repeat (3) begin
            @(negedge clk);
            s = sigOf(sel);
            dones += int'(s[2]);
        end
        expectEq({tag, "_latency"}, lat, expLat);
        expectEq({tag, "_edges"}, (sel ? edgesB : edgesA) - e0, 32'(amt));
        expectEq({tag, "_result"}, resOf(sel), expRes);
        expectEq({tag, "_dones"}, dones, 1);
        expectEq({tag, "_loads"}, loads, 1);
        expectEq({tag, "_high_cycles"}, highs, expHigh);
        expectEq({tag, "_overlap"}, overlap, 0);
        expectEq({tag, "_idle_after"}, sigOf(sel), 4'b0000);
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        setIn(1'b0, 1'b0, 4'h0, 3'd0);
        setIn(1'b1, 1'b0, 4'h0, 3'd0);
        repeat (2) @(negedge clk);
        expectEq("reset_a", allOutA(), 20'h0);
        expectEq("reset_b", {sigOf(1'b1), busB.sr_d, resOf(1'b1)}, 16'h0);
        rst = 1'b0;

        runOp("b_amt0", 1'b0, 4'hB, 3'd0, 3, 8'h0B, 0, 0);
        runOp("9_amt3", 1'b0, 4'h9, 3'd3, 9, 8'h48, 3, 0);
        runOp("f_amt7", 1'b0, 4'hF, 3'd7, 17, 8'h80, 7, 0);
`ifdef SHIFT_SEQ_OVF_EN
        expectEq("f_amt7_ovf", busA.ovf, 1'b1);
`endif
        runOp("f_amt4", 1'b0, 4'hF, 3'd4, 11, 8'hF0, 4, 0);
`ifdef SHIFT_SEQ_OVF_EN
        expectEq("f_amt4_ovf", busA.ovf, 1'b0);
`endif
        runOp("restart", 1'b0, 4'h9, 3'd3, 9, 8'h48, 3, 2);

        // Abort during the second SHIFT high phase.
        @(negedge clk);
        e0 = edgesA;
        setIn(1'b0, 1'b1, 4'h9, 3'd3);
        @(posedge clk);
        @(negedge clk);
        setIn(1'b0, 1'b0, 4'h9, 3'd3);
        repeat (3) @(negedge clk);
        expectEq("abort_pre_shift", busA.sr_shift, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        expectEq("abort_outputs", allOutA(), 20'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expectEq("abort_edges", edgesA - e0, 2);
        expectEq("abort_idle", sigOf(1'b0), 4'b0000);
        runOp("post_rst", 1'b0, 4'h1, 3'd2, 7, 8'h04, 2, 0);

        runOp("half2", 1'b1, 4'h3, 3'd2, 11, 8'h0C, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
